// File: rtl/result_collect.sv
// result_collect: gathers one selector transfer (scalar, vector or multi-round
// k-sort) into a word buffer, then drains it one 32-bit word per cycle.
//
// Ports:
//   clk, rst              clock, async active-high reset
//   in_valid/in_ready     selector beat handshake
//   in_sel                source code (001..011 vector, 100/101 scalar,
//                         110 k-sort, 000/111 illegal)
//   in_scalar, in_vector  beat payload (lane i at [32i+31:32i])
//   count                 k-sort round index presented to the selector
//   out_valid/out_ready   drain handshake
//   out_data/out_tag      drained word and the in_sel of its transfer
//   out_last              final word of the transfer
//   err                   sticky illegal-sel flag
//
// Optional feature: define KSORT_INDEX_EN to gather R index rounds after the
// R value rounds of a k-sort transfer (drain emits K values then K indices).
module result_collect #(
  parameter int K     = 20,
  parameter int LANES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_sel,
  input  logic [31:0]           in_scalar,
  input  logic [32*LANES-1:0]   in_vector,
  output logic [31:0]           count,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [2:0]            out_tag,
  output logic                  out_last,
  output logic                  err
);

  localparam int R = (K + LANES - 1) / LANES;
`ifdef KSORT_INDEX_EN
  localparam int ROUNDS = 2 * R;
  localparam int NK     = 2 * K;
`else
  localparam int ROUNDS = R;
  localparam int NK     = K;
`endif
  localparam int DEPTH = ROUNDS * LANES;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW    = $clog2(DEPTH + LANES + 1);

  typedef enum logic [1:0] {IDLE, GATHER, DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_buf [DEPTH];
  logic [AW-1:0]   r_p, r_n;
  logic [31:0]     r_count;
  logic [2:0]      r_tag;
  logic            r_err;

  logic            w_acc, w_is_vec, w_is_scl, w_is_ks, w_last_rnd;
  logic [AW-1:0]   w_ks_base, w_ks_lim, w_base, w_lim, w_n_nxt;
  logic            w_wr_vec, w_wr_scl, w_cnt_inc, w_clr, w_set_err, w_ld, w_p_inc;
  logic [AW-1:0]   w_idx [LANES];
  logic [LANES-1:0] w_wen;

  assign w_acc      = in_valid && in_ready;
  assign w_is_vec   = (in_sel == 3'b001) || (in_sel == 3'b010) || (in_sel == 3'b011);
  assign w_is_scl   = (in_sel == 3'b100) || (in_sel == 3'b101);
  assign w_is_ks    = (in_sel == 3'b110);
  assign w_last_rnd = (r_count == 32'(ROUNDS - 1));

  // Word window of the current k-sort round. Lanes past the limit (beyond K
  // in the final value or index round) are dropped.
  always_comb begin
    w_ks_base = AW'(r_count * LANES);
    w_ks_lim  = AW'(K);
`ifdef KSORT_INDEX_EN
    if (r_count >= 32'(R)) begin
      w_ks_base = AW'(K + (r_count - 32'(R)) * LANES);
      w_ks_lim  = AW'(2 * K);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_vec    = 1'b0;
    w_wr_scl    = 1'b0;
    w_cnt_inc   = 1'b0;
    w_clr       = 1'b0;
    w_set_err   = 1'b0;
    w_ld        = 1'b0;
    w_p_inc     = 1'b0;
    w_n_nxt     = r_n;
    w_base      = '0;
    w_lim       = AW'(LANES);
    case (r_state)
      IDLE: if (w_acc) begin
        if (w_is_vec) begin
          w_wr_vec = 1'b1; w_ld = 1'b1; w_n_nxt = AW'(LANES); w_state_nxt = DRAIN;
        end else if (w_is_scl) begin
          w_wr_scl = 1'b1; w_ld = 1'b1; w_n_nxt = AW'(1); w_state_nxt = DRAIN;
        end else if (w_is_ks) begin
          w_wr_vec = 1'b1; w_base = w_ks_base; w_lim = w_ks_lim;
          w_ld = 1'b1; w_n_nxt = AW'(NK); w_cnt_inc = 1'b1;
          w_state_nxt = (ROUNDS > 1) ? GATHER : DRAIN;
        end else begin
          w_set_err = 1'b1;
        end
      end
      GATHER: if (w_acc) begin
        if (w_is_ks) begin
          w_wr_vec = 1'b1; w_base = w_ks_base; w_lim = w_ks_lim; w_cnt_inc = 1'b1;
          if (w_last_rnd) w_state_nxt = DRAIN;
        end else begin
          w_set_err = 1'b1;
        end
      end
      DRAIN: if (out_ready) begin
        if (r_p == r_n - 1'b1) begin
          w_clr = 1'b1; w_state_nxt = IDLE;
        end else begin
          w_p_inc = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_idx[l] = w_base + AW'(l);
      w_wen[l] = w_wr_vec && (w_idx[l] < w_lim);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_p     <= '0;
      r_n     <= '0;
      r_tag   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_clr) begin
        r_count <= '0;
        r_p     <= '0;
      end else begin
        if (w_cnt_inc) r_count <= r_count + 32'd1;
        if (w_p_inc)   r_p     <= r_p + 1'b1;
      end
      if (w_ld) begin
        r_n   <= w_n_nxt;
        r_tag <= in_sel;
      end
      if (w_set_err) r_err <= 1'b1;
    end
  end

  // Buffer contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (w_wr_scl) r_buf[0] <= in_scalar;
    for (int l = 0; l < LANES; l++)
      if (w_wen[l]) r_buf[w_idx[l][IW-1:0]] <= in_vector[32*l +: 32];
  end

  assign in_ready  = !rst && (r_state != DRAIN);
  assign out_valid = (r_state == DRAIN);
  assign out_last  = (r_state == DRAIN) && (r_p == r_n - 1'b1);
  assign out_data  = (r_state == DRAIN) ? r_buf[r_p[IW-1:0]] : 32'd0;
  assign out_tag   = r_tag;
  assign count     = r_count;
  assign err       = r_err;

endmodule

// File: tb/tb_result_collect.sv
module tb_result_collect;
  localparam int K = 20;
  localparam int LANES = 16;

  logic                clk = 1'b0;
  logic                rst, in_valid, in_ready, out_valid, out_ready, out_last, err;
  logic [2:0]          in_sel, out_tag;
  logic [31:0]         in_scalar, count, out_data;
  logic [32*LANES-1:0] in_vector;

  result_collect #(.K(K), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_scalar(in_scalar), .in_vector(in_vector),
    .count(count), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_last(out_last), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_w [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  task automatic send(input logic [2:0] sel, input logic [31:0] s, input int vbase);
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_sel = sel; in_scalar = s;
    for (int l = 0; l < LANES; l++) in_vector[32*l +: 32] = 32'(vbase + l);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Drains words 0..nstop-1 of an n-word transfer, checking each against exp_w.
  task automatic drain(input int n, input int nstop, input bit tog, input logic [2:0] tag);
    int i = 0;
    int cyc = 0;
    @(negedge clk);
    chk("latency", 32'(out_valid), 32'd1);
    while (i < nstop && cyc < 400) begin
      out_ready = tog ? (cyc % 2 == 0) : 1'b1;
      chk("valid", 32'(out_valid), 32'd1);
      chk("data", out_data, exp_w[i]);
      chk("last", 32'(out_last), 32'(i == n - 1));
      chk("tag", 32'(out_tag), 32'(tag));
      if (out_ready) i++;
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("drain_cnt", 32'(i), 32'(nstop));
    if (nstop == n) chk("idle_after", 32'(out_valid), 32'd0);
  endtask

  task automatic ksort_exp();
    for (int i = 0; i < 16; i++) exp_w[i] = 32'(100 + i);
    for (int i = 0; i < 4; i++)  exp_w[16 + i] = 32'(200 + i);
`ifdef KSORT_INDEX_EN
    for (int i = 0; i < 20; i++) exp_w[20 + i] = 32'(i);
`endif
  endtask

  // Remaining k-sort beats after round 0, then the full drain.
  task automatic ksort_rest();
    send(3'b110, 32'd0, 200);
`ifdef KSORT_INDEX_EN
    send(3'b110, 32'd0, 0);
    send(3'b110, 32'd0, 16);
    drain(40, 40, 1'b0, 3'b110);
`else
    drain(20, 20, 1'b0, 3'b110);
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_sel = '0; in_scalar = '0; in_vector = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", count, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // scalar
    exp_w[0] = 32'hDEADBEEF;
    send(3'b100, 32'hDEADBEEF, 0);
    drain(1, 1, 1'b0, 3'b100);

    // vector with toggling backpressure
    for (int i = 0; i < 16; i++) exp_w[i] = 32'(i + 1);
    send(3'b010, 32'd0, 1);
    drain(16, 16, 1'b1, 3'b010);

    // k-sort, clean
    ksort_exp();
    chk("ks_cnt0", count, 32'd0);
    send(3'b110, 32'd0, 100);
    chk("ks_cnt1", count, 32'd1);
    chk("ks_gather_nv", 32'(out_valid), 32'd0);
    ksort_rest();
    chk("ks_cnt_end", count, 32'd0);
    chk("ks_err0", 32'(err), 32'd0);

    // k-sort with an illegal-source beat in GATHER
    send(3'b110, 32'd0, 100);
    send(3'b010, 32'd0, 500);
    chk("g_ill_cnt", count, 32'd1);
    chk("g_ill_err", 32'(err), 32'd1);
    chk("g_ill_nv", 32'(out_valid), 32'd0);
    ksort_rest();
    chk("g_ill_sticky", 32'(err), 32'd1);

    // reset clears err; illegal sel in IDLE
    @(negedge clk); rst = 1'b1; #1;
    chk("rst2_err", 32'(err), 32'd0);
    @(negedge clk); rst = 1'b0;
    send(3'b111, 32'd0, 0);
    chk("ill_nv", 32'(out_valid), 32'd0);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("ill_nv2", 32'(out_valid), 32'd0);

    // reset mid-drain
    for (int i = 0; i < 16; i++) exp_w[i] = 32'(i + 1);
    send(3'b001, 32'd0, 1);
    drain(16, 5, 1'b0, 3'b001);
    rst = 1'b1; #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", count, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
    exp_w[0] = 32'h12345678;
    send(3'b101, 32'h12345678, 0);
    drain(1, 1, 1'b0, 3'b101);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/result_collect.md
RESULT_COLLECT -- requirements
Module: result_collect

Interface
REQ-001 Parameter K, default 20, number of k-sort results per k-sort transfer (1..64).
REQ-002 Parameter LANES, default 16, vector width in 32-bit words.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  selector beat valid.
REQ-006 in_ready  output  1  collector accepts a beat; transfer occurs when in_valid && in_ready.
REQ-007 in_sel  input  3  source code: 001 counter, 010 adder, 011 multiplier (vector); 100 acc, 101 nonlin (scalar); 110 k-sort (multi-round vector).
REQ-008 in_scalar  input  32  scalar payload.
REQ-009 in_vector  input  32*LANES  vector payload, lane i at bits [32i+31:32i].
REQ-010 count  output  32  k-sort round index presented to the selector.
REQ-011 out_valid  output  1  drain word valid.
REQ-012 out_ready  input  1  downstream accepts the drain word.
REQ-013 out_data  output  32  drained word.
REQ-014 out_tag  output  3  in_sel of the transfer being drained.
REQ-015 out_last  output  1  final word of the current transfer.
REQ-016 err  output  1  sticky illegal-sel flag.

Function
REQ-017 FSM states IDLE, GATHER, DRAIN; in_ready SHALL be 1 in IDLE and GATHER only.
REQ-018 IDLE, accepted beat with vector sel: store LANES words, N=LANES, go DRAIN next cycle.
REQ-019 IDLE, accepted beat with scalar sel: store in_scalar, N=1, go DRAIN.
REQ-020 IDLE, accepted beat with sel 110: store lanes of round 0, increment count, go GATHER if R=ceil(K/LANES)>1, else DRAIN; N=K.
REQ-021 GATHER: each accepted beat stores lanes at word offset count*LANES; lanes with index >= K in the final round SHALL be discarded; count increments per beat; after round R-1 go DRAIN.
REQ-022 GATHER: a beat with in_sel != 110 SHALL be accepted, discarded, set err, and leave count unchanged.
REQ-023 IDLE: a beat with sel 000 or 111 SHALL be accepted, discarded, and set err; state stays IDLE.
REQ-024 DRAIN: out_valid=1; out_data = buffer word at drain pointer p (0..N-1); p advances on out_valid && out_ready; out_data held stable while out_ready=0.
REQ-025 out_last=1 when p==N-1; on its acceptance go IDLE, p=0, count=0, out_valid=0 the next cycle.
REQ-026 Capture-to-first-output latency SHALL be one cycle (out_valid rises the cycle after the final accepted beat).
REQ-027 Buffer depth SHALL be R*LANES words; no word written beyond index K-1 in k-sort mode.
REQ-028 Throughput: one drain word per cycle while out_ready=1; no bubbles inside a transfer.

Reset
REQ-029 On rst: state IDLE, count=0, p=0, out_valid=0, out_last=0, out_data=0, out_tag=0, err=0, in_ready=0 while rst asserted.
REQ-030 Reset asserted mid-GATHER or mid-DRAIN SHALL abandon the transfer; buffer contents are don't-care; in_ready=1 the first cycle after release.

Configuration
REQ-031 Macro KSORT_INDEX_EN: when defined, sel 110 gathers 2R rounds (R value rounds then R index rounds, count 0..2R-1), buffer 2R*LANES, N=2K, drain emits K values then K indices; when undefined, R rounds and N=K as above.

Verification
REQ-032 Scalar: sel=100, in_scalar=0xDEADBEEF, out_ready=1 -> one cycle later out_data=0xDEADBEEF, out_tag=100, out_last=1, then IDLE.
REQ-033 Vector backpressure: sel=010, lane i=i+1, out_ready toggling 1/0 -> words 1..16 in order, each held while out_ready=0, out_last on word 16.
REQ-034 K-sort K=20: beat0 lanes 100..115, beat1 lanes 200..215 -> count 0,1,then 0; drain 100..115,200..203 (20 words), out_last on 203.
REQ-035 Illegal sel: sel=111 in IDLE -> beat accepted, no out_valid, err=1 sticky until rst.
REQ-036 Reset mid-drain: rst after 5 of 16 words -> out_valid=0 immediately, count=0, next sel=101 beat drains normally.
REQ-037 With KSORT_INDEX_EN, K=20: 4 beats (values 100..,200.., indices 0..15,16..31) -> 40 words: 100..115,200..203,0..19.
